// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// Byte FIFO in front of a divided-baud shifter.
module uart_tx_fifo #(
  parameter int CLK_DIV = 434,
  parameter int ADDR_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            txd_ld,
  input  logic [7:0]      din,
  input  logic            ovf_clr,
  output logic            ser_txd,
  output logic            txd_busy,
  output logic            txd_empty,
  output logic            txd_ovf,
  output logic [ADDR_W:0] fifo_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W:0]   cnt, cnt_nx;
  logic [15:0]       baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shift, shift_nx;
  logic              line_nx, empty_nx;
  logic              full, push, pop, bit_end;

  assign full     = (cnt == FULL_CNT);
  assign push     = txd_ld && !full;
  assign pop      = (state == IDLE) && (cnt != '0);
  assign bit_end  = (state != IDLE) && (baud == '0);
  assign txd_busy = full;
  assign fifo_cnt = cnt;

  // FIFO storage; written only on an accepted push
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= din;
  end

  // occupancy count for push/pop combinations
  always_comb begin
    cnt_nx = cnt;
    unique case ({push, pop})
      2'b10:   cnt_nx = cnt + 1'b1;
      2'b01:   cnt_nx = cnt - 1'b1;
      default: cnt_nx = cnt;
    endcase
  end

  // FIFO pointers, count and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      txd_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nx;
      if (txd_ld && full) txd_ovf <= 1'b1;
      else if (ovf_clr) txd_ovf <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (pop) state_nx = START;
      START: if (bit_end) state_nx = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_nx = STOP;
      STOP:  if (bit_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // next line level and status, registered below
  always_comb begin
    shift_nx = shift;
    if (pop) shift_nx = mem[rd_ptr];
    else if (state == DATA && bit_end) shift_nx = shift >> 1;
    line_nx = 1'b1;
    unique case (state_nx)
      START:   line_nx = 1'b0;
      DATA:    line_nx = shift_nx[0];
      default: line_nx = 1'b1;
    endcase
    empty_nx = (cnt_nx == '0) && (state_nx == IDLE);
  end

  // baud timing, shifter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      baud      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      ser_txd   <= 1'b1;
      txd_empty <= 1'b1;
    end else begin
      if (pop) begin
        baud    <= DIV_M1;
        bit_idx <= '0;
      end else if (bit_end) begin
        baud <= (state_nx == IDLE) ? '0 : DIV_M1;
        if (state == DATA) bit_idx <= bit_idx + 1'b1;
      end else if (baud != '0) begin
        baud <= baud - 1'b1;
      end
      shift     <= shift_nx;
      ser_txd   <= line_nx;
      txd_empty <= empty_nx;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter between the device controller's byte-store path (UART data address, SB) and the board serial pin ser_txd.
- Accepts bytes into a small FIFO at CPU speed and serialises them as 8N1 frames, LSB first, at a fixed divided baud rate.
- Reports busy/empty/overflow status for the controller's status-read word.

Parameters:
- CLK_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- txd_ld  input  1  write strobe; push din into FIFO this cycle.
- din  input  8  byte to transmit.
- ovf_clr  input  1  clears sticky overflow flag.
- ser_txd  output  1  serial line; idle high.
- txd_busy  output  1  FIFO full (further writes are dropped).
- txd_empty  output  1  FIFO empty AND shifter idle (line quiescent).
- txd_ovf  output  1  sticky: a write was dropped because FIFO was full.
- fifo_cnt  output  ADDR_W+1  number of queued bytes, excluding the byte in the shifter.

Behaviour:
- Reset (rst high at an edge): ser_txd=1, txd_busy=0, txd_empty=1, txd_ovf=0, fifo_cnt=0, FSM=IDLE, pointers=0, baud counter=0. Reset mid-frame aborts immediately: the line returns high on the next edge and queued bytes are discarded.
- FIFO: circular buffer with separate rd/wr pointers plus an occupancy counter.
  - txd_busy = (fifo_cnt == 2**ADDR_W).
  - Push: txd_ld && !txd_busy; the full check uses the pre-edge count.
  - Push is refused when full even if a pop occurs in the same cycle.
  - A refused push sets txd_ovf. txd_ovf holds until ovf_clr. If ovf_clr and a refused push coincide, set wins.
  - Simultaneous push and pop: fifo_cnt unchanged, both pointers advance and wrap modulo depth.
- FSM states:
  - IDLE: ser_txd=1. If fifo_cnt != 0, then on this edge pop the head into an 8-bit shift register, load the baud counter with CLK_DIV-1, and go to START.
  - START: ser_txd=0 for CLK_DIV cycles.
  - DATA: 8 bits, each CLK_DIV cycles. ser_txd = shift[0]; shift right at each bit end. A 3-bit bit index counts 0..7.
  - STOP: ser_txd=1 for CLK_DIV cycles. At the end, go to IDLE.
  - Back-to-back bytes therefore get exactly one IDLE cycle between the stop bit and the next start bit.
- Baud counter: counts down to 0. When it is 0 and the state is not IDLE, the bit ends and the counter reloads CLK_DIV-1. Each bit is exactly CLK_DIV clocks. The frame is 10*CLK_DIV clocks.
- ser_txd is driven from a register; it is never combinational from the FSM.
- Latency: txd_ld high at edge E0 with the FIFO empty and the FSM in IDLE:
  - fifo_cnt=1 after E0.
  - Pop at E1: fifo_cnt=0 and ser_txd=0 after E1.
  - ser_txd returns high (stop bit) after E1+9*CLK_DIV.
  - FSM is IDLE and txd_empty=1 after E1+10*CLK_DIV.
- txd_empty is registered and equals (fifo_cnt==0 && FSM==IDLE) as of the current state.
- din is sampled only on an accepted push. Changes to din later do not affect queued data.

Test Plan:
- Single byte, CLK_DIV=4: push 0xA5 at E0 -> ser_txd low on cycles E1..E1+3, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles; txd_empty=1 after E1+40.
- Burst: push 0x00, 0xFF, 0x55 on consecutive cycles -> fifo_cnt 1,2,3 then decrements at each pop; three frames separated by exactly 1 idle cycle.
- Overflow, ADDR_W=2: push 6 bytes in consecutive cycles while idle:
  - the first byte is popped at E1, so 5 fit;
  - txd_busy=1 after the 5th push;
  - the 6th push is dropped and txd_ovf=1;
  - serial output carries bytes 1-5 only;
  - ovf_clr pulse -> txd_ovf=0.
- Simultaneous push+pop with the FIFO full -> push refused, txd_ovf=1, fifo_cnt decrements by 1. With the FIFO partially full -> fifo_cnt unchanged, data order preserved across pointer wrap.
- Reset mid-DATA (bit 3 of 0x3C) -> ser_txd=1 after the reset edge, fifo_cnt=0, txd_empty=1; a later push of 0x81 transmits cleanly with the correct timing.
- Minimum divider CLK_DIV=2: push 0x01 -> start 2 cycles, bit0=1 for 2 cycles, bits1-7=0, stop 2 cycles; total 20 cycles.
